pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: CLK input 1 (rising-edge clock); Reset_n input 1 (asynchronous, active-low reset).
REQ-002 SHALL have port PCOut, input, 16 bits: current PC fed back from the PC register.
REQ-003 SHALL have port PCTop, input, 3 bits: PC register top bits PC[15:13].
REQ-004 SHALL have port Advance, input, 1 bit: request one PC update; sampled only when Ready=1.
REQ-005 SHALL have port Stall, input, 1 bit: holds off acceptance of Advance.
REQ-006 SHALL have port BranchTaken, input, 1 bit: with BranchOff[7:0] (signed word offset), selects a relative branch.
REQ-007 SHALL have port Jump, input, 1 bit: with JumpImm[11:0], selects an absolute jump.
REQ-008 SHALL have ports Call and Ret, inputs, 1 bit each: subroutine call and return.
REQ-009 SHALL have port PCNext, output, 16 bits: drives the PC register data input.
REQ-010 SHALL have port PCWrite, output, 1 bit: one-cycle write strobe to the PC register.
REQ-011 SHALL have port Ready, output, 1 bit: high when the sequencer can accept Advance.
REQ-012 SHALL have ports StackOvf and StackUnf, outputs, 1 bit each: sticky return-stack error flags.

Function
REQ-013 SHALL implement FSM states IDLE, WRITE, SETTLE; Ready=1 only in IDLE.
REQ-014 In IDLE, Advance=1 with Stall=0 SHALL latch all selector inputs and compute PCNext, then go to WRITE; otherwise it SHALL stay in IDLE.
REQ-015 WRITE SHALL last one cycle with PCWrite=1 and PCNext stable, then go to SETTLE.
REQ-016 SETTLE SHALL last one cycle with PCWrite=0 (PC feedback update), then go to IDLE.
REQ-017 Throughput SHALL be: Advance accepted at edge N gives PCWrite high during cycle N+1 and Ready high again in cycle N+3.
REQ-018 Advance while Ready=0 SHALL be ignored, not queued.
REQ-019 Target priority SHALL be Ret > Call > Jump > BranchTaken > sequential; lower selectors are ignored when a higher one is asserted.
REQ-020 Sequential target SHALL be PCOut+2.
REQ-021 Branch target SHALL be PCOut+2+(sign_extend(BranchOff)<<1).
REQ-022 Jump and Call target SHALL be {PCTop, JumpImm, 1'b0}.
REQ-023 All additions SHALL wrap modulo 2^16.
REQ-024 Call SHALL push PCOut+2 onto the return stack; Ret SHALL pop it as the target.
REQ-025 Return stack SHALL be 4 entries, circular; a push when full SHALL overwrite the oldest entry and set StackOvf.
REQ-026 Ret when the stack is empty SHALL use target PCOut+2, leave the stack unchanged, and set StackUnf.
REQ-027 PCNext SHALL hold its last value in IDLE and SETTLE.

Reset
REQ-028 Reset_n=0 SHALL immediately force: state IDLE, PCWrite=0, PCNext=16'h0000, Ready=1 (once released), stack empty, StackOvf=0, StackUnf=0.
REQ-029 Reset asserted in WRITE or SETTLE SHALL abort the update; no PCWrite pulse SHALL follow reset release.
REQ-030 StackOvf and StackUnf SHALL be cleared only by reset.

Configuration
REQ-031 Macro PCSEQ_RAS_EN defined SHALL compile in the return stack and REQ-024..026.
REQ-032 Macro PCSEQ_RAS_EN undefined SHALL treat Call as Jump and Ret as sequential; StackOvf and StackUnf SHALL be tied 0.

Verification
REQ-033 Reset, PCOut=16'h0040, Advance pulse -> PCWrite high exactly one cycle, PCNext=16'h0042; Ready low two cycles.
REQ-034 PCOut=16'h0100, BranchTaken=1, BranchOff=8'hFC -> PCNext=16'h00FA; BranchOff=8'h7F at PCOut=16'hFFF0 -> PCNext=16'h00F0 (wrap).
REQ-035 PCTop=3'b101, Jump=1, JumpImm=12'hABC, BranchTaken=1 -> PCNext=16'hB578 (jump wins).
REQ-036 (PCSEQ_RAS_EN) Five Calls at PCOut=16'h0010,0x20,0x30,0x40,0x50, then four Rets -> targets 0x52,0x42,0x32,0x22, StackOvf=1; fifth Ret at PCOut=16'h0022 -> PCNext=16'h0024, StackUnf=1.
REQ-037 Advance with Stall=1 for 3 cycles -> no PCWrite; Advance during SETTLE -> ignored; Reset_n low during WRITE -> PCWrite drops at once, PCNext=0.
REQ-038 (PCSEQ_RAS_EN undefined) Call with PCTop=0, JumpImm=12'h010 -> PCNext=16'h0020; Ret at PCOut=16'h0020 -> PCNext=16'h0022, flags stay 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/WRITE/SETTLE handshake that computes the next PC
// (sequential, branch, jump, call, return). Optional return stack under `PCSEQ_RAS_EN.
module pc_sequencer (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic [15:0] PCOut,
  input  logic [2:0]  PCTop,
  input  logic        Advance,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [7:0]  BranchOff,
  input  logic        Jump,
  input  logic [11:0] JumpImm,
  input  logic        Call,
  input  logic        Ret,
  output logic [15:0] PCNext,
  output logic        PCWrite,
  output logic        Ready,
  output logic        StackOvf,
  output logic        StackUnf
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic [15:0] seq_pc;
  logic [15:0] br_pc;
  logic [15:0] abs_pc;
  logic [15:0] target;
  logic        push;
  logic        pop;

  assign accept  = (state == IDLE) && Advance && !Stall;
  assign Ready   = (state == IDLE);
  // PCWrite decodes the state directly so an asynchronous reset kills the strobe at once.
  assign PCWrite = (state == WRITE);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WRITE;
      WRITE:   state_nxt = SETTLE;
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Candidate targets; all arithmetic wraps at 16 bits
  // ---------------------------------------------------------------------------
  assign seq_pc = PCOut + 16'd2;
  assign br_pc  = seq_pc + {{7{BranchOff[7]}}, BranchOff, 1'b0};
  assign abs_pc = {PCTop, JumpImm, 1'b0};

`ifdef PCSEQ_RAS_EN
  localparam int RAS_DEPTH = 4;

  logic [15:0] ras_mem [RAS_DEPTH];
  logic [1:0]  ras_sp;      // next free slot; top of stack is ras_sp-1
  logic [2:0]  ras_cnt;
  logic        ras_empty;
  logic        ras_full;
  logic [15:0] ras_top;
  logic        ovf_q;
  logic        unf_q;

  assign ras_empty = (ras_cnt == 3'd0);
  assign ras_full  = (ras_cnt == 3'(RAS_DEPTH));
  assign ras_top   = ras_mem[ras_sp - 2'd1];

  always_comb begin
    target = seq_pc;
    push   = 1'b0;
    pop    = 1'b0;
    if (Ret) begin
      pop    = 1'b1;
      target = ras_empty ? seq_pc : ras_top;
    end else if (Call) begin
      push   = 1'b1;
      target = abs_pc;
    end else if (Jump) begin
      target = abs_pc;
    end else if (BranchTaken) begin
      target = br_pc;
    end
  end

  // Pointer, occupancy and sticky flags; a full push wraps onto the oldest entry.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      ras_sp  <= 2'd0;
      ras_cnt <= 3'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (accept && push) begin
      ras_sp <= ras_sp + 2'd1;
      if (ras_full) ovf_q   <= 1'b1;
      else          ras_cnt <= ras_cnt + 3'd1;
    end else if (accept && pop) begin
      if (ras_empty) begin
        unf_q <= 1'b1;
      end else begin
        ras_sp  <= ras_sp - 2'd1;
        ras_cnt <= ras_cnt - 3'd1;
      end
    end
  end

  // NOTE: the stack storage has no reset; occupancy is tracked by ras_cnt, so
  // stale contents are never read and the array maps onto plain flops/RAM.
  always_ff @(posedge CLK) begin
    if (accept && push) ras_mem[ras_sp] <= seq_pc;
  end

  assign StackOvf = ovf_q;
  assign StackUnf = unf_q;
`else
  // Without the return stack, Call behaves as Jump and Ret as sequential.
  always_comb begin
    target = seq_pc;
    push   = 1'b0;
    pop    = 1'b0;
    if (Ret) begin
      target = seq_pc;
    end else if (Call || Jump) begin
      target = abs_pc;
    end else if (BranchTaken) begin
      target = br_pc;
    end
  end

  assign StackOvf = 1'b0;
  assign StackUnf = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // PCNext is captured on acceptance and held through WRITE, SETTLE and IDLE
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n)    PCNext <= 16'h0000;
    else if (accept) PCNext <= target;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table of directed PC-update vectors plus
// hand-written sequences for stall, advance-while-busy and reset-in-WRITE.
module tb_pc_sequencer;

  logic        CLK;
  logic        Reset_n;
  logic [15:0] PCOut;
  logic [2:0]  PCTop;
  logic        Advance;
  logic        Stall;
  logic        BranchTaken;
  logic [7:0]  BranchOff;
  logic        Jump;
  logic [11:0] JumpImm;
  logic        Call;
  logic        Ret;
  logic [15:0] PCNext;
  logic        PCWrite;
  logic        Ready;
  logic        StackOvf;
  logic        StackUnf;

  int checks   = 0;
  int failures = 0;

  pc_sequencer dut (
    .CLK(CLK), .Reset_n(Reset_n), .PCOut(PCOut), .PCTop(PCTop),
    .Advance(Advance), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchOff(BranchOff), .Jump(Jump), .JumpImm(JumpImm),
    .Call(Call), .Ret(Ret), .PCNext(PCNext), .PCWrite(PCWrite),
    .Ready(Ready), .StackOvf(StackOvf), .StackUnf(StackUnf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [15:0] pcout;
    logic [2:0]  pctop;
    logic        br;
    logic [7:0]  off;
    logic        jmp;
    logic [11:0] imm;
    logic        call;
    logic        ret;
    logic [15:0] exp_pc;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [15:0] pcout, logic [2:0] pctop,
                              logic br, logic [7:0] off, logic jmp, logic [11:0] imm,
                              logic call, logic ret, logic [15:0] exp_pc,
                              logic exp_ovf, logic exp_unf);
    vec_t v;
    v.name = name; v.pcout = pcout; v.pctop = pctop; v.br = br; v.off = off;
    v.jmp = jmp; v.imm = imm; v.call = call; v.ret = ret; v.exp_pc = exp_pc;
    v.exp_ovf = exp_ovf; v.exp_unf = exp_unf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    Advance = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchOff = 8'h00;
    Jump = 1'b0; JumpImm = 12'h000; Call = 1'b0; Ret = 1'b0; PCTop = 3'b000;
  endtask

  // Drive at a negedge, accept on the following posedge, then observe WRITE,
  // SETTLE and the return to IDLE at the next three negedges.
  task automatic apply_vec(input vec_t v);
    @(negedge CLK);
    check({v.name, ".ready_before"}, 32'(Ready), 32'd1);
    PCOut = v.pcout; PCTop = v.pctop; BranchTaken = v.br; BranchOff = v.off;
    Jump = v.jmp; JumpImm = v.imm; Call = v.call; Ret = v.ret; Advance = 1'b1;
    @(negedge CLK);
    clear_inputs();
    check({v.name, ".pcwrite"}, 32'(PCWrite), 32'd1);
    check({v.name, ".pcnext"},  32'(PCNext),  32'(v.exp_pc));
    check({v.name, ".ready_w"}, 32'(Ready),   32'd0);
    @(negedge CLK);
    check({v.name, ".pcwrite_s"}, 32'(PCWrite), 32'd0);
    check({v.name, ".ready_s"},   32'(Ready),   32'd0);
    check({v.name, ".pcnext_s"},  32'(PCNext),  32'(v.exp_pc));
    @(negedge CLK);
    check({v.name, ".ready_i"},  32'(Ready),    32'd1);
    check({v.name, ".pcnext_i"}, 32'(PCNext),   32'(v.exp_pc));
    check({v.name, ".ovf"},      32'(StackOvf), 32'(v.exp_ovf));
    check({v.name, ".unf"},      32'(StackUnf), 32'(v.exp_unf));
  endtask

  initial begin
    // Common vectors: {name, pcout, pctop, br, off, jmp, imm, call, ret, exp_pc, ovf, unf}
    vecs.push_back(mk("seq_0040",  16'h0040, 3'd0, 1'b0, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 16'h0042, 1'b0, 1'b0));
    vecs.push_back(mk("br_back",   16'h0100, 3'd0, 1'b1, 8'hFC, 1'b0, 12'h000, 1'b0, 1'b0, 16'h00FA, 1'b0, 1'b0));
    vecs.push_back(mk("br_wrap",   16'hFFF0, 3'd0, 1'b1, 8'h7F, 1'b0, 12'h000, 1'b0, 1'b0, 16'h00F0, 1'b0, 1'b0));
    vecs.push_back(mk("jump_wins", 16'h1234, 3'd5, 1'b1, 8'h05, 1'b1, 12'hABC, 1'b0, 1'b0, 16'hB578, 1'b0, 1'b0));
    vecs.push_back(mk("seq_wrap",  16'hFFFE, 3'd0, 1'b0, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mk("br_min",    16'h1000, 3'd0, 1'b1, 8'h80, 1'b0, 12'h000, 1'b0, 1'b0, 16'h0F02, 1'b0, 1'b0));
`ifdef PCSEQ_RAS_EN
    vecs.push_back(mk("call_1", 16'h0010, 3'd0, 1'b0, 8'h00, 1'b0, 12'h100, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0));
    vecs.push_back(mk("call_2", 16'h0020, 3'd0, 1'b0, 8'h00, 1'b0, 12'h100, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0));
    vecs.push_back(mk("call_3", 16'h0030, 3'd0, 1'b0, 8'h00, 1'b0, 12'h100, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0));
    vecs.push_back(mk("call_4", 16'h0040, 3'd0, 1'b0, 8'h00, 1'b0, 12'h100, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0));
    vecs.push_back(mk("call_5", 16'h0050, 3'd0, 1'b0, 8'h00, 1'b0, 12'h100, 1'b1, 1'b0, 16'h0200, 1'b1, 1'b0));
    vecs.push_back(mk("ret_1",  16'h0200, 3'd0, 1'b1, 8'h10, 1'b1, 12'h000, 1'b1, 1'b1, 16'h0052, 1'b1, 1'b0));
    vecs.push_back(mk("ret_2",  16'h0200, 3'd0, 1'b0, 8'h00, 1'b0, 12'h000, 1'b0, 1'b1, 16'h0042, 1'b1, 1'b0));
    vecs.push_back(mk("ret_3",  16'h0200, 3'd0, 1'b0, 8'h00, 1'b0, 12'h000, 1'b0, 1'b1, 16'h0032, 1'b1, 1'b0));
    vecs.push_back(mk("ret_4",  16'h0200, 3'd0, 1'b0, 8'h00, 1'b0, 12'h000, 1'b0, 1'b1, 16'h0022, 1'b1, 1'b0));
    vecs.push_back(mk("ret_unf",16'h0022, 3'd0, 1'b0, 8'h00, 1'b0, 12'h000, 1'b0, 1'b1, 16'h0024, 1'b1, 1'b1));
`else
    vecs.push_back(mk("call_jmp",  16'h0300, 3'd0, 1'b0, 8'h00, 1'b0, 12'h010, 1'b1, 1'b0, 16'h0020, 1'b0, 1'b0));
    vecs.push_back(mk("ret_seq",   16'h0020, 3'd0, 1'b0, 8'h00, 1'b0, 12'h000, 1'b0, 1'b1, 16'h0022, 1'b0, 1'b0));
    vecs.push_back(mk("call_vs_br",16'h0500, 3'd2, 1'b1, 8'h04, 1'b0, 12'h123, 1'b1, 1'b0, 16'h4246, 1'b0, 1'b0));
`endif

    clear_inputs();
    PCOut   = 16'h0000;
    Reset_n = 1'b0;
    #12;
    check("reset.pcwrite", 32'(PCWrite),  32'd0);
    check("reset.pcnext",  32'(PCNext),   32'h0000);
    check("reset.ready",   32'(Ready),    32'd1);
    check("reset.ovf",     32'(StackOvf), 32'd0);
    check("reset.unf",     32'(StackUnf), 32'd0);
    @(negedge CLK);
    Reset_n = 1'b1;

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Advance held with Stall=1 for three cycles: nothing accepted.
    @(negedge CLK);
    PCOut = 16'h0700; Advance = 1'b1; Stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("stall.pcwrite", 32'(PCWrite), 32'd0);
      check("stall.ready",   32'(Ready),   32'd1);
    end
    clear_inputs();
    check("stall.pcnext_held", 32'(PCNext), 32'(vecs[vecs.size()-1].exp_pc));

    // Advance presented only during SETTLE is dropped.
    @(negedge CLK);
    PCOut = 16'h0800; Advance = 1'b1;
    @(negedge CLK);
    Advance = 1'b0;
    check("busy.pcnext", 32'(PCNext), 32'h0802);
    @(negedge CLK);
    PCOut = 16'h0900; Advance = 1'b1;
    @(negedge CLK);
    Advance = 1'b0;
    check("busy.ready_idle", 32'(Ready), 32'd1);
    @(negedge CLK);
    check("busy.no_write", 32'(PCWrite), 32'd0);
    check("busy.pcnext",   32'(PCNext),  32'h0802);

    // Reset during WRITE aborts the update immediately.
    @(negedge CLK);
    PCOut = 16'h0A00; Advance = 1'b1;
    @(negedge CLK);
    Advance = 1'b0;
    check("rstw.pcwrite_pre", 32'(PCWrite), 32'd1);
    Reset_n = 1'b0;
    #1;
    check("rstw.pcwrite", 32'(PCWrite),  32'd0);
    check("rstw.pcnext",  32'(PCNext),   32'h0000);
    check("rstw.ready",   32'(Ready),    32'd1);
    check("rstw.ovf",     32'(StackOvf), 32'd0);
    check("rstw.unf",     32'(StackUnf), 32'd0);
    @(negedge CLK);
    Reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("rstw.no_write", 32'(PCWrite), 32'd0);
      check("rstw.pcnext_0", 32'(PCNext),  32'h0000);
    end

    // Sequencer still works after the aborted update.
    apply_vec(mk("post_rst", 16'h0B00, 3'd0, 1'b0, 8'h00, 1'b0, 12'h000, 1'b0, 1'b0, 16'h0B02, 1'b0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
